// File: rtl/stream_mux_rr.sv
// stream_mux_rr -- registered NUM_CH-to-1 stream multiplexer with round-robin
// arbitration and valid/ready handshakes on every channel and on the output.
//
// Each cycle the arbiter picks one requesting channel, starting at the
// round-robin pointer and wrapping. The chosen beat moves into a single output
// register whenever that register is empty or being drained.
//
// Optional feature (compile-time macro STREAM_MUX_PKT_LOCK_EN):
//   When defined, a packet lock keeps the grant on one channel from its first
//   non-last beat until its last beat. Without the macro, arbitration runs per
//   beat and in_last is only passed through.
//
// Ports:
//   clk          in   1             rising-edge clock
//   rst_n        in   1             asynchronous active-low reset
//   i_in_valid   in   NUM_CH        per-channel beat valid
//   i_in_data    in   NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   i_in_last    in   NUM_CH        per-channel end-of-packet flag
//   o_in_ready   out  NUM_CH        per-channel accept (combinational, one-hot or 0)
//   o_out_valid  out  1             output register holds a beat
//   o_out_data   out  WIDTH         registered data
//   o_out_last   out  1             registered last flag
//   o_out_ch     out  CHW           channel that supplied o_out_data
//   i_out_ready  in   1             sink accept
module stream_mux_rr #(
   parameter int NUM_CH = 8,
   parameter int WIDTH  = 8,
   localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       i_in_valid,
   input  logic [NUM_CH*WIDTH-1:0] i_in_data,
   input  logic [NUM_CH-1:0]       i_in_last,
   output logic [NUM_CH-1:0]       o_in_ready,
   output logic                    o_out_valid,
   output logic [WIDTH-1:0]        o_out_data,
   output logic                    o_out_last,
   output logic [CHW-1:0]          o_out_ch,
   input  logic                    i_out_ready
);

   localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
   localparam logic [CHW:0]   NUM_CH_W = (CHW+1)'(NUM_CH);

   logic [CHW-1:0]    r_ptr;
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic              r_out_last;
   logic [CHW-1:0]    r_out_ch;

   logic [CHW:0]      w_sum;
   logic [CHW-1:0]    w_idx;
   logic [CHW-1:0]    w_rr_idx;
   logic              w_rr_found;
   logic [CHW-1:0]    w_gidx;
   logic              w_found;
   logic [NUM_CH-1:0] w_grant;
   logic              w_load;
   logic              w_xfer;
   logic [WIDTH-1:0]  w_sel_data;
   logic              w_sel_last;
   logic [CHW-1:0]    w_next_ptr;

`ifdef STREAM_MUX_PKT_LOCK_EN
   typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_t;
   lock_state_t    r_state;
   logic [CHW-1:0] r_lock_ch;
`endif

   // Round-robin search: first valid channel at ptr, ptr+1, ... with wrap.
   always_comb begin
      w_rr_idx   = '0;
      w_rr_found = 1'b0;
      w_sum      = '0;
      w_idx      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_sum = {1'b0, r_ptr} + (CHW+1)'(k);
         if (w_sum >= NUM_CH_W) begin
            w_sum = w_sum - NUM_CH_W;
         end else begin
            w_sum = w_sum;
         end
         w_idx = w_sum[CHW-1:0];
         if (!w_rr_found && i_in_valid[w_idx]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_idx;
         end else begin
            w_rr_found = w_rr_found;
         end
      end
   end

   // Final grant choice; a held packet lock overrides the round-robin pick.
   always_comb begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (r_state == ST_LOCKED) begin
         w_gidx  = r_lock_ch;
         w_found = i_in_valid[r_lock_ch];
      end else begin
         w_gidx  = w_rr_idx;
         w_found = w_rr_found;
      end
`else
      w_gidx  = w_rr_idx;
      w_found = w_rr_found;
`endif
   end

   // Handshake: the output register can load when empty or being drained;
   // nothing is accepted while reset is asserted.
   always_comb begin
      w_load = rst_n & (~r_out_valid | i_out_ready);
      w_xfer = w_found & w_load;
      if (w_found) begin
         w_grant = NUM_CH'(1'b1) << w_gidx;
      end else begin
         w_grant = '0;
      end
      o_in_ready = w_grant & {NUM_CH{w_load}};
   end

   // Data/last mux for the granted channel and the pointer value after it.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_gidx == CHW'(i)) begin
            w_sel_data = i_in_data[i*WIDTH +: WIDTH];
         end else begin
            w_sel_data = w_sel_data;
         end
      end
      w_sel_last = i_in_last[w_gidx];
      if (w_gidx == LAST_CH) begin
         w_next_ptr = '0;
      end else begin
         w_next_ptr = w_gidx + CHW'(1);
      end
   end

   // Output register: loads a granted beat, empties on load without a grant,
   // holds everything while stalled by the sink.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_ch    <= '0;
      end else if (w_load) begin
         r_out_valid <= w_xfer;
         if (w_xfer) begin
            r_out_data <= w_sel_data;
            r_out_last <= w_sel_last;
            r_out_ch   <= w_gidx;
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   // Lock FSM and pointer: a non-last beat locks onto its channel, the last
   // beat of that packet unlocks and moves the pointer past the channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_UNLOCKED;
         r_lock_ch <= '0;
         r_ptr     <= '0;
      end else begin
         case (r_state)
            ST_UNLOCKED: begin
               if (w_xfer) begin
                  r_ptr <= w_next_ptr;
                  if (!w_sel_last) begin
                     r_state   <= ST_LOCKED;
                     r_lock_ch <= w_gidx;
                  end
               end
            end
            ST_LOCKED: begin
               // w_gidx equals r_lock_ch here, so w_next_ptr is lock_ch+1.
               if (w_xfer && w_sel_last) begin
                  r_state <= ST_UNLOCKED;
                  r_ptr   <= w_next_ptr;
               end
            end
            default: begin
               r_state <= ST_UNLOCKED;
            end
         endcase
      end
   end
`else
   // Pointer advances past the channel granted on each transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= w_next_ptr;
      end
   end
`endif

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr -- directed, scoreboard-checked bench for stream_mux_rr
// (default parameters NUM_CH=8, WIDTH=8). Stimulus pushes each expected
// output beat into a queue; a forked monitor pops and compares on every
// output handshake. Expectations follow STREAM_MUX_PKT_LOCK_EN when defined.
module tb_stream_mux_rr;

   localparam int NUM_CH = 8;
   localparam int WIDTH  = 8;
   localparam int CHW    = 3;

   typedef struct packed {
      logic [CHW-1:0]   ch;
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       i_in_valid;
   logic [NUM_CH*WIDTH-1:0] i_in_data;
   logic [NUM_CH-1:0]       i_in_last;
   logic [NUM_CH-1:0]       o_in_ready;
   logic                    o_out_valid;
   logic [WIDTH-1:0]        o_out_data;
   logic                    o_out_last;
   logic [CHW-1:0]          o_out_ch;
   logic                    i_out_ready;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   stream_mux_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .i_in_data   (i_in_data),
      .i_in_last   (i_in_last),
      .o_in_ready  (o_in_ready),
      .o_out_valid (o_out_valid),
      .o_out_data  (o_out_data),
      .o_out_last  (o_out_last),
      .o_out_ch    (o_out_ch),
      .i_out_ready (i_out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic set_ch(input int ch, input logic [WIDTH-1:0] d, input logic l);
      i_in_data[ch*WIDTH +: WIDTH] = d;
      i_in_last[ch]                = l;
   endtask

   task automatic push_exp(input int ch, input logic [WIDTH-1:0] d, input logic l);
      beat_t b;
      b.ch   = CHW'(ch);
      b.data = d;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic monitor();
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got ch %0d data %0h, expected none", o_out_ch, o_out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_ch",   32'(o_out_ch),   32'(e.ch));
               check("out_data", 32'(o_out_data), 32'(e.data));
               check("out_last", 32'(o_out_last), 32'(e.last));
            end
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tbl[6];
      int b2;
      int g;
      logic [NUM_CH-1:0] v;

      rst_n       = 1'b0;
      i_in_valid  = 8'hFF;
      i_in_data   = '0;
      i_in_last   = '0;
      i_out_ready = 1'b1;
      fork
         monitor();
      join_none

      // Reset state with every channel requesting.
      @(negedge clk);
      check("rst_out_valid", 32'(o_out_valid), 32'd0);
      check("rst_in_ready",  32'(o_in_ready),  32'd0);
      check("rst_out_ch",    32'(o_out_ch),    32'd0);
      check("rst_out_data",  32'(o_out_data),  32'd0);
      next_cycle();
      rst_n      = 1'b1;
      i_in_valid = 8'h00;

      // Single beat on channel 3.
      next_cycle();
      set_ch(3, 8'hA5, 1'b1);
      i_in_valid = 8'h08;
      push_exp(3, 8'hA5, 1'b1);
      @(negedge clk);
      check("single_in_ready", 32'(o_in_ready), 32'h08);
      next_cycle();
      i_in_valid = 8'h00;
      @(negedge clk);
      check("single_out_valid", 32'(o_out_valid), 32'd1);
      next_cycle();

      // Reset mid-stream: beat from ch6 stalled in the output, then discarded.
      set_ch(6, 8'h66, 1'b1);
      i_in_valid  = 8'h40;
      i_out_ready = 1'b0;
      next_cycle();
      i_in_valid = 8'h00;
      @(negedge clk);
      check("mid_out_valid", 32'(o_out_valid), 32'd1);
      check("mid_out_ch",    32'(o_out_ch),    32'd6);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
      check("mid_rst_out_ch",    32'(o_out_ch),    32'd0);
      next_cycle();
      rst_n       = 1'b1;
      i_out_ready = 1'b1;

      // Fairness: all channels requesting, pointer restarts at 0.
      for (int i = 0; i < NUM_CH; i++) set_ch(i, 8'(8'h30 + i), 1'b1);
      i_in_valid = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         push_exp(k % 8, 8'(8'h30 + (k % 8)), 1'b1);
         @(negedge clk);
         check("fair_in_ready", 32'(o_in_ready), 32'(1) << (k % 8));
         next_cycle();
      end
      i_in_valid = 8'h00;
      next_cycle();

      // Backpressure: ch7 beat stalled 3 cycles while ch0 waits.
      set_ch(7, 8'h77, 1'b1);
      set_ch(0, 8'h0A, 1'b1);
      i_in_valid  = 8'h81;
      i_out_ready = 1'b0;
      push_exp(7, 8'h77, 1'b1);
      @(negedge clk);
      check("bp_first_in_ready", 32'(o_in_ready), 32'h80);
      next_cycle();
      i_in_valid = 8'h01;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_stall_in_ready", 32'(o_in_ready),  32'h00);
         check("bp_stall_data",     32'(o_out_data),  32'h77);
         check("bp_stall_valid",    32'(o_out_valid), 32'd1);
         next_cycle();
      end
      i_out_ready = 1'b1;
      push_exp(0, 8'h0A, 1'b1);
      @(negedge clk);
      check("bp_release_in_ready", 32'(o_in_ready), 32'h01);
      next_cycle();
      i_in_valid = 8'h00;
      next_cycle();

      // Packet test: ch2 sends a 3-beat packet, ch5 single-beat packets.
`ifdef STREAM_MUX_PKT_LOCK_EN
      tbl = '{2, 2, 2, 5, 5, 5};
`else
      tbl = '{2, 5, 2, 5, 2, 5};
`endif
      b2 = 1;
      set_ch(5, 8'h55, 1'b1);
      for (int c = 0; c < 6; c++) begin
         v = 8'h20;
         if (b2 <= 3) v = v | 8'h04;
         set_ch(2, 8'(8'hC0 + b2), (b2 == 3));
         i_in_valid = v;
         g = tbl[c];
         if (g == 5) push_exp(5, 8'h55, 1'b1);
         else        push_exp(2, 8'(8'hC0 + b2), (b2 == 3));
         @(negedge clk);
         check("pkt_in_ready", 32'(o_in_ready), 32'(1) << g);
         next_cycle();
         if (g == 2) b2++;
      end
      i_in_valid = 8'h00;

      // Drain and final state.
      repeat (3) next_cycle();
      @(negedge clk);
      check("idle_out_valid", 32'(o_out_valid), 32'd0);
      check("queue_empty",    32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
